// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned RSIZE_DEF = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned REG_ZERO  = 0;

  function automatic int unsigned idx_w(input int unsigned nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_bypass_sel.sv
// Per-read-port bypass selector: highest-index enabled write port matching rd_idx_i wins.
module regfile_bypass_sel
  import regfile_pkg::*;
#(
  parameter int unsigned RSIZE = RSIZE_DEF,
  parameter int unsigned NWR   = 1,
  parameter int unsigned IDX_W = 5
) (
  input  logic [IDX_W-1:0]     rd_idx_i,
  input  logic [NWR-1:0]       wr_en_i,
  input  logic [NWR*IDX_W-1:0] wr_idx_i,
  input  logic [NWR*RSIZE-1:0] wr_data_i,
  output logic                 hit_c_o,
  output logic [RSIZE-1:0]     data_c_o
);

  // Ascending scan so the last (highest) matching port overrides earlier ones.
  always_comb begin
    hit_c_o  = 1'b0;
    data_c_o = '0;
    for (int w = 0; w < int'(NWR); w++) begin
      if (wr_en_i[w] && (wr_idx_i[w*IDX_W +: IDX_W] == rd_idx_i)) begin
        hit_c_o  = 1'b1;
        data_c_o = wr_data_i[w*RSIZE +: RSIZE];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write bypass and r0 hardwired to zero.
// Optional pending scoreboard enabled by defining REGFILE_SCOREBOARD_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned RSIZE = RSIZE_DEF,
  parameter  int unsigned NREGS = NREGS_DEF,
  parameter  int unsigned NRD   = 2,
  parameter  int unsigned NWR   = 1,
  localparam int unsigned IDX_W = idx_w(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*IDX_W-1:0] rd_idx,
  output logic [NRD*RSIZE-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*IDX_W-1:0] wr_idx,
  input  logic [NWR*RSIZE-1:0] wr_data,
  input  logic                 issue_en,
  input  logic [IDX_W-1:0]     issue_idx
);

  logic [RSIZE-1:0] mem_q [NREGS];
  logic [RSIZE-1:0] mem_d [NREGS];
  logic [NRD-1:0]   hit_c;
  logic [RSIZE-1:0] byp_c [NRD];

  // Write merge: later (higher) ports override earlier ones on the same index.
  always_comb begin
    mem_d = mem_q;
    for (int w = 0; w < int'(NWR); w++) begin
      if (wr_en[w] && (wr_idx[w*IDX_W +: IDX_W] != IDX_W'(REG_ZERO))) begin
        mem_d[wr_idx[w*IDX_W +: IDX_W]] = wr_data[w*RSIZE +: RSIZE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar p = 0; p < int'(NRD); p++) begin : g_rd
    regfile_bypass_sel #(
      .RSIZE (RSIZE),
      .NWR   (NWR),
      .IDX_W (IDX_W)
    ) u_sel (
      .rd_idx_i  (rd_idx[p*IDX_W +: IDX_W]),
      .wr_en_i   (wr_en),
      .wr_idx_i  (wr_idx),
      .wr_data_i (wr_data),
      .hit_c_o   (hit_c[p]),
      .data_c_o  (byp_c[p])
    );
  end

  // Read mux; reset gates every port to zero.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < int'(NRD); p++) begin
      if (!rst && (rd_idx[p*IDX_W +: IDX_W] != IDX_W'(REG_ZERO))) begin
        rd_data[p*RSIZE +: RSIZE] = hit_c[p] ? byp_c[p] : mem_q[rd_idx[p*IDX_W +: IDX_W]];
      end
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  // Writes retire producers; a same-cycle issue re-arms the bit afterwards.
  always_comb begin
    pend_d = pend_q;
    for (int w = 0; w < int'(NWR); w++) begin
      if (wr_en[w]) begin
        pend_d[wr_idx[w*IDX_W +: IDX_W]] = 1'b0;
      end
    end
    if (issue_en) begin
      pend_d[issue_idx] = 1'b1;
    end
    pend_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int p = 0; p < int'(NRD); p++) begin
      if (!rst) begin
        rd_busy[p] = pend_q[rd_idx[p*IDX_W +: IDX_W]] & ~hit_c[p];
      end
    end
  end
`else
  logic unused_issue;
  assign unused_issue = ^{issue_en, issue_idx};
  assign rd_busy      = '0;
`endif

endmodule
